// File: rtl/uart_transmitter.sv
// UART transmitter: byte FIFO feeding a start/8-data(MSB first)/stop serialiser.
// A frame launches only from idle while cts is high; cts is ignored once the frame is on the line.
module uart_transmitter #(
  parameter int unsigned SYMBOL_EDGE_TIME = 868,
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter int unsigned STOP_SYMBOLS     = 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [7:0]                          data_in,
  input  logic                                data_in_valid,
  output logic                                data_in_ready,
  output logic                                serial_out,
  input  logic                                cts,
  output logic                                busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);

  localparam int unsigned CountW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned TickW  = $clog2(STOP_SYMBOLS * SYMBOL_EDGE_TIME);
  localparam logic [TickW-1:0] SymLast  = TickW'(SYMBOL_EDGE_TIME - 1);
  localparam logic [TickW-1:0] StopLast = TickW'(STOP_SYMBOLS * SYMBOL_EDGE_TIME - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q, count_d;
  state_e            state_q, state_d;
  logic [TickW-1:0]  tick_q, tick_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              serial_q, serial_d;
  logic              busy_q, busy_d;
  logic              push, pop;

  assign data_in_ready = (count_q < CountW'(FIFO_DEPTH));
  assign push          = data_in_valid && data_in_ready;
  assign fifo_count    = count_q;
  assign serial_out    = serial_q;
  assign busy          = busy_q;

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CountW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CountW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        tick_d = '0;
        if ((count_q != '0) && cts) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          bit_d   = 3'd7;
          state_d = StStart;
        end
      end
      StStart: begin
        if (tick_q == SymLast) begin
          tick_d  = '0;
          state_d = StData;
        end else begin
          tick_d = tick_q + TickW'(1);
        end
      end
      StData: begin
        if (tick_q == SymLast) begin
          tick_d = '0;
          if (bit_q == 3'd0) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end else begin
          tick_d = tick_q + TickW'(1);
        end
      end
      StStop: begin
        if (tick_q == StopLast) begin
          tick_d  = '0;
          state_d = StIdle;
        end else begin
          tick_d = tick_q + TickW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level is decoded from the next state so it lands in a flop on the same edge.
  always_comb begin
    serial_d = 1'b1;
    busy_d   = 1'b1;
    unique case (state_d)
      StIdle: begin
        serial_d = 1'b1;
        busy_d   = 1'b0;
      end
      StStart: serial_d = 1'b0;
      StData:  serial_d = shift_d[bit_d];
      StStop:  serial_d = 1'b1;
      default: begin
        serial_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: frame-timing reference model, line decoder and directed sequences.
module tb_uart_transmitter;

  localparam int unsigned Set   = 8;
  localparam int unsigned Depth = 4;
  localparam int unsigned Stop  = 1;
  localparam int          Frame = (9 + Stop) * Set;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = '0;
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic       serial_out;
  logic       cts = 1'b0;
  logic       busy;
  logic [2:0] fifo_count;

  uart_transmitter #(
    .SYMBOL_EDGE_TIME(Set),
    .FIFO_DEPTH      (Depth),
    .STOP_SYMBOLS    (Stop)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .serial_out   (serial_out),
    .cts          (cts),
    .busy         (busy),
    .fifo_count   (fifo_count)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: byte queue plus the edge index at which the current frame launched.
  int         e = 0;
  logic [7:0] m_q[$];
  logic [7:0] m_sent[$];
  bit         have_frame = 0;
  int         frame_l = 0;
  logic [7:0] frame_byte = '0;

  // Line decoder, sampling mid-symbol.
  bit         rx_active = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = '0;
  logic [7:0] rx_q[$];

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       c;
    int         cnt;
    logic       rdy;
    logic       bsy;
    logic       ser;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_serial();
    int off;
    int k;
    off = e - frame_l;
    if (!have_frame || off >= Frame) return 1;
    k = off / Set;
    if (k == 0) return 0;
    if (k <= 8) return int'(frame_byte[8-k]);
    return 1;
  endfunction

  function automatic int exp_busy();
    return (have_frame && (e - frame_l) < Frame) ? 1 : 0;
  endfunction

  task automatic model_edge(input logic v, input logic [7:0] d, input logic c);
    bit idle;
    int sz;
    e++;
    idle = !have_frame || (e - frame_l >= Frame + 1);
    sz   = m_q.size();
    if (idle && sz > 0 && c) begin
      frame_byte = m_q.pop_front();
      frame_l    = e;
      have_frame = 1;
      m_sent.push_back(frame_byte);
    end
    if (v && sz < Depth) m_q.push_back(d);
  endtask

  task automatic mon_sample();
    if (!rx_active) begin
      if (serial_out === 1'b0) begin
        rx_active = 1;
        rx_cnt    = 0;
        rx_byte   = '0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == Set / 2) check("rx_start", int'(serial_out), 0);
      if ((rx_cnt % Set) == Set / 2 && rx_cnt / Set >= 1 && rx_cnt / Set <= 8)
        rx_byte = {rx_byte[6:0], serial_out};
      if (rx_cnt == 9 * Set + Set / 2) begin
        check("rx_stop", int'(serial_out), 1);
        rx_q.push_back(rx_byte);
        rx_active = 0;
      end
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic c);
    data_in_valid = v;
    data_in       = d;
    cts           = c;
    @(posedge clock);
    model_edge(v, d, c);
    #1;
    check("serial_out", int'(serial_out), exp_serial());
    check("busy", int'(busy), exp_busy());
    check("fifo_count", int'(fifo_count), m_q.size());
    check("data_in_ready", int'(data_in_ready), (m_q.size() < Depth) ? 1 : 0);
    mon_sample();
  endtask

  task automatic idle_steps(input int n, input logic c);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, c);
  endtask

  // Asynchronous reset asserted between edges; outputs must settle before the next edge.
  task automatic do_reset(input string name);
    #2;
    reset = 1'b0;
    #1;
    check({name, "_serial"}, int'(serial_out), 1);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_count"}, int'(fifo_count), 0);
    check({name, "_ready"}, int'(data_in_ready), 1);
    m_q.delete();
    m_sent.delete();
    rx_q.delete();
    have_frame = 0;
    rx_active  = 0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic check_rx_vs_model(input string name);
    check({name, "_rx_len"}, rx_q.size(), m_sent.size());
    for (int i = 0; i < rx_q.size() && i < m_sent.size(); i++)
      check({name, "_rx_byte"}, int'(rx_q[i]), int'(m_sent[i]));
  endtask

  initial begin
    vec_t       tbl[7];
    logic [7:0] exp6[4];
    logic [7:0] exp_tbl[5];
    int         busy_cycles;
    bit         accepted;
    bit         ready_pre;

    tbl[0] = '{v: 1'b1, d: 8'hAA, c: 1'b1, cnt: 1, rdy: 1'b1, bsy: 1'b0, ser: 1'b1};
    tbl[1] = '{v: 1'b1, d: 8'hBB, c: 1'b1, cnt: 1, rdy: 1'b1, bsy: 1'b1, ser: 1'b0};
    tbl[2] = '{v: 1'b1, d: 8'hCC, c: 1'b1, cnt: 2, rdy: 1'b1, bsy: 1'b1, ser: 1'b0};
    tbl[3] = '{v: 1'b1, d: 8'hDD, c: 1'b0, cnt: 3, rdy: 1'b1, bsy: 1'b1, ser: 1'b0};
    tbl[4] = '{v: 1'b1, d: 8'hEE, c: 1'b0, cnt: 4, rdy: 1'b0, bsy: 1'b1, ser: 1'b0};
    tbl[5] = '{v: 1'b1, d: 8'hFF, c: 1'b0, cnt: 4, rdy: 1'b0, bsy: 1'b1, ser: 1'b0};
    tbl[6] = '{v: 1'b0, d: 8'h00, c: 1'b0, cnt: 4, rdy: 1'b0, bsy: 1'b1, ser: 1'b0};
    exp_tbl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    exp6    = '{8'h00, 8'hFF, 8'h5A, 8'h81};

    // Reset while idle with bytes queued, then mid-frame.
    @(negedge clock);
    do_reset("rst_init");
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    do_reset("rst_idle");
    step(1'b1, 8'h5A, 1'b1);
    step(1'b1, 8'h11, 1'b0);
    idle_steps(20, 1'b0);
    do_reset("rst_midframe");
    idle_steps(12, 1'b1);

    // Table: simultaneous push/pop, fill to full, refusal while full.
    do_reset("rst_tbl");
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].c);
      check("tbl_count", int'(fifo_count), tbl[i].cnt);
      check("tbl_ready", int'(data_in_ready), int'(tbl[i].rdy));
      check("tbl_busy", int'(busy), int'(tbl[i].bsy));
      check("tbl_serial", int'(serial_out), int'(tbl[i].ser));
    end
    idle_steps(5 * (Frame + 1) + 10, 1'b1);
    check("tbl_rx_len", rx_q.size(), 5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++) check("tbl_rx", int'(rx_q[i]), int'(exp_tbl[i]));

    // Single 0xA5 frame: start on the pop edge, busy for exactly one frame.
    do_reset("rst_a5");
    step(1'b1, 8'hA5, 1'b1);
    busy_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 8'h00, 1'b1);
      if (i == 0) check("a5_start_low", int'(serial_out), 0);
      if (busy) busy_cycles++;
    end
    check("a5_busy_len", busy_cycles, Frame);
    check("a5_rx_len", rx_q.size(), 1);
    if (rx_q.size() > 0) check("a5_rx", int'(rx_q[0]), 8'hA5);

    // Valid held over six bytes; the sixth waits until a pop frees space.
    do_reset("rst_burst");
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b1);
    check("burst_full_count", int'(fifo_count), 4);
    check("burst_full_ready", int'(data_in_ready), 0);
    accepted = 0;
    for (int g = 0; g < 2000 && !accepted; g++) begin
      ready_pre = (m_q.size() < Depth);
      step(1'b1, 8'h06, 1'b1);
      if (ready_pre) accepted = 1;
    end
    check("burst_accepted", int'(accepted), 1);
    idle_steps(6 * (Frame + 1) + 10, 1'b1);
    check("burst_rx_len", rx_q.size(), 6);
    for (int i = 0; i < 6 && i < rx_q.size(); i++) check("burst_rx", int'(rx_q[i]), i + 1);

    // cts low holds the byte; raising it launches on the next edge.
    do_reset("rst_cts");
    step(1'b1, 8'h3C, 1'b0);
    idle_steps(200, 1'b0);
    check("cts_hold_count", int'(fifo_count), 1);
    check("cts_hold_line", int'(serial_out), 1);
    step(1'b0, 8'h00, 1'b1);
    check("cts_launch", int'(serial_out), 0);
    idle_steps(Frame + 5, 1'b0);
    check("cts_rx_len", rx_q.size(), 1);
    if (rx_q.size() > 0) check("cts_rx", int'(rx_q[0]), 8'h3C);

    // cts drops during data bit 4: frame finishes, next byte waits.
    do_reset("rst_drop");
    step(1'b1, 8'h96, 1'b1);
    step(1'b1, 8'h69, 1'b1);
    idle_steps(34, 1'b1);
    idle_steps(150, 1'b0);
    check("drop_rx_len", rx_q.size(), 1);
    if (rx_q.size() > 0) check("drop_rx", int'(rx_q[0]), 8'h96);
    check("drop_wait_count", int'(fifo_count), 1);
    idle_steps(Frame + 10, 1'b1);
    check("drop_rx_len2", rx_q.size(), 2);
    if (rx_q.size() > 1) check("drop_rx2", int'(rx_q[1]), 8'h69);

    // Back-to-back loopback bytes.
    do_reset("rst_loop");
    for (int i = 0; i < 4; i++) step(1'b1, exp6[i], 1'b1);
    idle_steps(4 * (Frame + 1) + 20, 1'b1);
    check("loop_rx_len", rx_q.size(), 4);
    for (int i = 0; i < 4 && i < rx_q.size(); i++) check("loop_rx", int'(rx_q[i]), int'(exp6[i]));

    // Randomised traffic against the model.
    do_reset("rst_rand");
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 3) != 0));
    idle_steps(6 * (Frame + 1) + 10, 1'b1);
    check_rx_vs_model("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
